// File: rtl/inc_step_pipe_pkg.sv
// Shared types for the registered incrementer pipeline.
package inc_step_pipe_pkg;

  // Arithmetic mode selected per transaction.
  typedef enum logic {
    ModeWrap = 1'b0,
    ModeSat  = 1'b1
  } inc_mode_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/inc_step_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry catches one extra word while the output is stalled.
module inc_step_pipe_skid_buf #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             w_accept;
  logic             w_xfer;

  // in_ready comes straight from the skid flag, so it never depends on out_ready.
  assign in_ready  = !r_skid_valid;
  assign w_accept  = in_valid && !r_skid_valid;
  assign w_xfer    = r_main_valid && out_ready;
  assign out_data  = r_main_data;
  assign out_valid = r_main_valid;

  // Main/skid entry update; accept with skid full cannot happen as in_ready is low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_xfer) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_data  <= in_data;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid) begin
        r_main_data  <= in_data;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_data  <= in_data;
        r_skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inc_step_pipe.sv
// Registered incrementer: d = a + step in wrap or saturate mode, with carry-out
// flag, a 2-entry skid on the output and a saturating overflow event counter.
module inc_step_pipe
  import inc_step_pipe_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] step,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] d,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNTWIDTH-1:0]  ovf_count
);

  // Returns {ovf, d}; ovf is the carry-out in both modes.
  function automatic logic [DATAWIDTH:0] inc_calc(input logic [DATAWIDTH-1:0] a_v,
                                                  input logic [DATAWIDTH-1:0] step_v,
                                                  input logic             mode_v);
    logic [DATAWIDTH:0] sum;
    sum = {1'b0, a_v} + {1'b0, step_v};
    if (inc_mode_e'(mode_v) == ModeSat && sum[DATAWIDTH]) begin
      return {1'b1, {DATAWIDTH{1'b1}}};
    end
    return sum;
  endfunction

  logic [DATAWIDTH:0]  w_calc;
  logic [DATAWIDTH:0]  w_out;
  logic [CNTWIDTH-1:0] r_ovf_count;

  assign w_calc = inc_calc(a, step, mode);

  inc_step_pipe_skid_buf #(
    .WIDTH (DATAWIDTH + 1)
  ) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (w_calc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign d         = w_out[DATAWIDTH-1:0];
  assign ovf       = w_out[DATAWIDTH];
  assign ovf_count = r_ovf_count;

  // Count overflow results as they leave the block, holding at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ovf_count <= '0;
    end else if (out_valid && out_ready && ovf && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inc_step_pipe.sv
// Scoreboard bench for inc_step_pipe (DATAWIDTH=8, CNTWIDTH=2).
module tb_inc_step_pipe;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] a;
  logic [7:0] step;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] ovf_count;

  int         n_total = 0;
  int         n_bad   = 0;
  bit         mon_en  = 1'b0;
  logic [8:0] sb_q[$];
  int         exp_cnt = 0;

  inc_step_pipe #(
    .DATAWIDTH (8),
    .CNTWIDTH  (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .a         (a),
    .step      (step),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_count (ovf_count)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result {ovf, d} from integer arithmetic.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] sv,
                                       input logic mv);
    int  s;
    bit  c;
    s = int'(av) + int'(sv);
    c = (s > 255);
    if (mv && c) return {1'b1, 8'hFF};
    return {c, s[7:0]};
  endfunction

  // Inputs change #1 after posedge, so the negedge sees what the next edge will act on.
  always @(negedge Clk) begin
    if (mon_en) begin
      check_eq("out_valid", out_valid, sb_q.size() != 0);
      check_eq("in_ready", in_ready, sb_q.size() < 2);
      check_eq("ovf_count", ovf_count, exp_cnt);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", sb_q.size(), 1);
        end else begin
          check_eq("d", d, sb_q[0][7:0]);
          check_eq("ovf", ovf, sb_q[0][8]);
        end
      end
      if (Rst) begin
        sb_q.delete();
        exp_cnt = 0;
      end else begin
        if (out_valid && out_ready && sb_q.size() != 0) begin
          if (sb_q[0][8] && exp_cnt < 3) exp_cnt++;
          void'(sb_q.pop_front());
        end
        if (in_valid && in_ready) sb_q.push_back(model(a, step, mode));
      end
    end
  end

  // Present one transaction and hold it until accepted (caller sits at posedge+1).
  task automatic send(input logic [7:0] av, input logic [7:0] sv, input logic mv);
    int k;
    a = av; step = sv; mode = mv; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge Clk); #1;
      k++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    @(posedge Clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      @(posedge Clk); #1;
      k++;
    end
    check_eq("drain", sb_q.size(), 0);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; a = '0; step = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // 1. Reset
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_d", d, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_count", ovf_count, 0);
    check_eq("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // 2. Wrap: FE + 3 -> 01 with carry
    send(8'hFE, 8'd3, 1'b0);
    idle();
    check_eq("wrap_valid", out_valid, 1);
    check_eq("wrap_d", d, 8'h01);
    check_eq("wrap_ovf", ovf, 1);
    @(posedge Clk); #1;
    check_eq("wrap_count", ovf_count, 1);

    // 3. Saturate
    send(8'hFE, 8'd3, 1'b1);
    send(8'h10, 8'd5, 1'b1);
    idle();
    drain();
    check_eq("sat_count", ovf_count, 2);

    // 4. Backpressure: stall, fill both entries, then release
    out_ready = 1'b0;
    send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd1, 1'b0);
    check_eq("bp_in_ready_low", in_ready, 0);
    fork
      send(8'd3, 8'd1, 1'b0);
      begin
        repeat (3) @(posedge Clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(8'd4, 8'd1, 1'b0);
    idle();
    drain();

    // 5. Counter saturation from a clean count
    pulse_reset();
    for (int i = 0; i < 5; i++) send(8'hFF, 8'd1, 1'b0);
    idle();
    drain();
    @(posedge Clk); #1;
    check_eq("cnt_sat", ovf_count, 3);

    // 6. Reset with both entries full
    out_ready = 1'b0;
    send(8'hFF, 8'd2, 1'b0);
    send(8'h20, 8'd2, 1'b1);
    idle();
    check_eq("mid_full", in_ready, 0);
    pulse_reset();
    check_eq("mid_out_valid", out_valid, 0);
    check_eq("mid_in_ready", in_ready, 1);
    check_eq("mid_count", ovf_count, 0);
    out_ready = 1'b1;
    send(8'd7, 8'd1, 1'b0);
    idle();
    check_eq("post_rst_d", d, 8'd8);
    drain();

    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
